calc_display_scan: RTL and testbench

- Receiving end of the calculator's result interface (status, pos, data).
- Captures 4-bit BCD digits addressed by pos into an internal digit buffer, interprets calculator status, and time-multiplexes the buffer onto a common-anode 7-segment bank.
- Sits between the calculator core and the board display pins.

---
 rtl/calc_display_scan.sv | 121 ++++++++++++
 tb/tb_calc_display_scan.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scan.sv
// Result-interface receiver for the calculator: buffers BCD digits addressed by pos and
// time-multiplexes them onto a common-anode 7-segment bank with leading-zero blanking.
module calc_display_scan #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] pos,
  input  logic [3:0] data,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    StErro    = 2'd0,
    StPronta  = 2'd1,
    StOcupada = 2'd2,
    StErroAlt = 2'd3
  } status_e;

  logic [3:0]      digit_q [DIGITS];
  logic [3:0]      digit_d [DIGITS];
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  status_e         prev_status_q, prev_status_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       is_err, prev_err;
  logic [2:0] high;
  logic [3:0] cur;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    is_err        = (status == StErro) || (status == StErroAlt);
    prev_err      = (prev_status_q == StErro) || (prev_status_q == StErroAlt);
    prev_status_d = status_e'(status);

    // Clear on entry to error; no writes are accepted while in error so it stays clear.
    digit_d = digit_q;
    if (is_err && !prev_err) begin
      for (int i = 0; i < int'(DIGITS); i++) digit_d[i] = 4'd0;
    end else if (status == StPronta) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (pos == 4'(i)) digit_d[i] = data;
      end
    end

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end

    high = 3'd0;
    cur  = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digit_q[i] != 4'd0) high = 3'(i);
      if (idx_q == 3'(i))     cur  = digit_q[i];
    end

    an_d        = 8'hFF;
    an_d[idx_q] = 1'b0;
    if (is_err) begin
      seg_d = (idx_q == 3'd0) ? 7'h06 : 7'h7F;
      dp_d  = 1'b1;
    end else begin
      seg_d = (idx_q <= high) ? bcd_to_seg(cur) : 7'h7F;
      dp_d  = (status != StOcupada);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DIGITS); i++) digit_q[i] <= 4'd0;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      prev_status_q <= StPronta;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      for (int i = 0; i < int'(DIGITS); i++) digit_q[i] <= digit_d[i];
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      prev_status_q <= prev_status_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_calc_display_scan.sv
// Directed bench for calc_display_scan: three instances (8 digits / div 4, 4 digits / div 4,
// 8 digits / div 1) share one stimulus stream; expected values are hand-computed.
module tb_calc_display_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'd1;
  logic [3:0] pos = 4'd15;
  logic [3:0] data = 4'd0;

  logic [7:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  calc_display_scan #(.DIGITS(8), .SCAN_DIV(4)) dut_a (
    .clock(clock), .reset(reset), .status(status), .pos(pos), .data(data),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  calc_display_scan #(.DIGITS(4), .SCAN_DIV(4)) dut_b (
    .clock(clock), .reset(reset), .status(status), .pos(pos), .data(data),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  calc_display_scan #(.DIGITS(8), .SCAN_DIV(1)) dut_c (
    .clock(clock), .reset(reset), .status(status), .pos(pos), .data(data),
    .an(an_c), .seg(seg_c), .dp(dp_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [3:0] p, input logic [3:0] d);
    @(negedge clock);
    status = s;
    pos    = p;
    data   = d;
  endtask

  // Wait (bounded) until dut_a scans digit d, then check its segments and dp.
  task automatic scan_to(input int d, input logic [6:0] exp_seg, input logic exp_dp,
                         input string tag);
    logic [7:0] tgt;
    int n;
    tgt    = 8'hFF;
    tgt[d] = 1'b0;
    n      = 0;
    do begin
      @(negedge clock);
      n++;
    end while (an_a !== tgt && n < 48);
    chk({tag, "/an"}, an_a, tgt);
    chk({tag, "/seg"}, {1'b0, seg_a}, {1'b0, exp_seg});
    chk({tag, "/dp"}, {7'd0, dp_a}, {7'd0, exp_dp});
  endtask

  initial begin
    logic [7:0] exp_an;
    int n;

    // Reset state
    #1 reset = 1'b0;
    #2;
    chk("rst_an_a", an_a, 8'hFF);
    chk("rst_seg_a", {1'b0, seg_a}, 8'h7F);
    chk("rst_dp_a", {7'd0, dp_a}, 8'h01);
    chk("rst_an_b", an_b, 8'hFF);
    chk("rst_an_c", an_c, 8'hFF);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Empty buffer scan: each digit held 4 clocks, only digit 0 lit with "0"
    for (int c = 0; c < 33; c++) begin
      @(negedge clock);
      exp_an = 8'hFF;
      exp_an[(c / 4) % 8] = 1'b0;
      chk($sformatf("scan0_an_c%0d", c), an_a, exp_an);
      chk($sformatf("scan0_seg_c%0d", c), {1'b0, seg_a},
          (((c / 4) % 8) == 0) ? 8'h40 : 8'h7F);
      chk($sformatf("scan0_dp_c%0d", c), {7'd0, dp_a}, 8'h01);
      if (c == 0) chk("div1_first", an_c, 8'hFE);
      if (c == 1) chk("div1_second", an_c, 8'hFD);
    end

    // 503 with an interior zero
    drive(2'd1, 4'd2, 4'd5);
    drive(2'd1, 4'd0, 4'd3);
    drive(2'd1, 4'd15, 4'd0);
    scan_to(2, 7'h12, 1'b1, "w_d2");
    scan_to(1, 7'h40, 1'b1, "w_d1");
    scan_to(0, 7'h30, 1'b1, "w_d0");
    scan_to(3, 7'h7F, 1'b1, "w_d3");
    scan_to(7, 7'h7F, 1'b1, "w_d7");

    // Busy: writes ignored, dp lit on every digit
    drive(2'd2, 4'd0, 4'd9);
    scan_to(0, 7'h30, 1'b0, "busy_d0");
    scan_to(2, 7'h12, 1'b0, "busy_d2");
    scan_to(5, 7'h7F, 1'b0, "busy_d5");
    drive(2'd1, 4'd15, 4'd0);
    scan_to(0, 7'h30, 1'b1, "ready_d0");

    // Error entry clears 735; writes during error ignored
    drive(2'd1, 4'd2, 4'd7);
    drive(2'd1, 4'd1, 4'd3);
    drive(2'd1, 4'd0, 4'd5);
    drive(2'd1, 4'd15, 4'd0);
    scan_to(2, 7'h78, 1'b1, "n735_d2");
    scan_to(1, 7'h30, 1'b1, "n735_d1");
    scan_to(0, 7'h12, 1'b1, "n735_d0");
    drive(2'd0, 4'd0, 4'd9);
    scan_to(0, 7'h06, 1'b1, "err_d0");
    scan_to(1, 7'h7F, 1'b1, "err_d1");
    scan_to(2, 7'h7F, 1'b1, "err_d2");
    drive(2'd1, 4'd15, 4'd0);
    scan_to(0, 7'h40, 1'b1, "clr_d0");
    scan_to(2, 7'h7F, 1'b1, "clr_d2");

    // Status 3 behaves as error
    drive(2'd1, 4'd1, 4'd8);
    drive(2'd3, 4'd15, 4'd0);
    scan_to(0, 7'h06, 1'b1, "st3_d0");
    scan_to(1, 7'h7F, 1'b1, "st3_d1");
    drive(2'd1, 4'd15, 4'd0);
    scan_to(1, 7'h7F, 1'b1, "st3clr_d1");
    scan_to(0, 7'h40, 1'b1, "st3clr_d0");

    // Out-of-range positions, non-BCD values, further digits
    drive(2'd1, 4'd8, 4'd7);
    drive(2'd1, 4'd15, 4'd7);
    drive(2'd1, 4'd15, 4'd0);
    scan_to(0, 7'h40, 1'b1, "oor_d0");
    scan_to(7, 7'h7F, 1'b1, "oor_d7");
    drive(2'd1, 4'd0, 4'd12);
    drive(2'd1, 4'd15, 4'd0);
    scan_to(0, 7'h7F, 1'b1, "nonbcd_d0");
    drive(2'd1, 4'd3, 4'd9);
    drive(2'd1, 4'd0, 4'd8);
    drive(2'd1, 4'd15, 4'd0);
    scan_to(3, 7'h10, 1'b1, "n9008_d3");
    scan_to(1, 7'h40, 1'b1, "n9008_d1");
    scan_to(0, 7'h00, 1'b1, "n9008_d0");

    // Four-digit instance: upper enables idle, wrap after digit 3
    n = 0;
    do begin
      @(negedge clock);
      n++;
      chk("d4_upper", {4'd0, an_b[7:4]}, 8'h0F);
    end while (an_b !== 8'hF7 && n < 24);
    chk("d4_reach3", an_b, 8'hF7);
    chk("d4_seg3", {1'b0, seg_b}, 8'h10);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (an_b === 8'hF7 && n < 8);
    chk("d4_wrap", an_b, 8'hFE);
    chk("d4_seg0", {1'b0, seg_b}, 8'h00);

    // Asynchronous reset between edges
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_an_a", an_a, 8'hFF);
    chk("arst_seg_a", {1'b0, seg_a}, 8'h7F);
    chk("arst_dp_a", {7'd0, dp_a}, 8'h01);
    chk("arst_an_c", an_c, 8'hFF);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_an_c1", an_c, 8'hFE);
    chk("rel_an_a1", an_a, 8'hFE);
    chk("rel_seg_a1", {1'b0, seg_a}, 8'h40);
    @(negedge clock);
    chk("rel_an_c2", an_c, 8'hFD);
    chk("rel_an_a2", an_a, 8'hFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
